// File: rtl/dmadd_seq_if.sv
// ------------------------------------------------------------------
// dmadd_seq_if : host command / result handshake bundle for dmadd_seq
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface dmadd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_index;
  logic [3:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_index;
  logic       res_found;
  logic       res_stale;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_index, res_found, res_stale
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_data, res_ready,
    output cmd_ready, res_valid, res_index, res_found, res_stale
  );
endinterface

`default_nettype wire

// File: rtl/dmadd_seq.sv
// ------------------------------------------------------------------
// dmadd_seq : command sequencer for the DMADD delta min/max datapath;
//             DMADD_SEQ_CHECK_EN adds the res_err self-check.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dmadd_seq #(
  parameter int SCAN_CYCLES = 17,
  parameter int CLR_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmadd_seq_if.slave  bus,
  output logic        bad_cmd,
  output logic        dp_rst_n,
  output logic [3:0]  dp_index,
  output logic [3:0]  dp_data,
  output logic [1:0]  dp_insn,
  output logic        dp_load,
  output logic        dp_run,
  input  logic [11:0] dp_out
`ifdef DMADD_SEQ_CHECK_EN
  ,
  output logic        res_err
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_CLR  = 3'd3;
  localparam logic [2:0] S_PRE  = 3'd4;
  localparam logic [2:0] S_RUN  = 3'd5;
  localparam logic [2:0] S_CAPT = 3'd6;
  localparam logic [2:0] S_RESP = 3'd7;

  localparam logic [2:0] OP_INIT_MIN = 3'd0;
  localparam logic [2:0] OP_INIT_MAX = 3'd1;
  localparam logic [2:0] OP_LOAD     = 3'd2;
  localparam logic [2:0] OP_RUN      = 3'd3;
  localparam logic [2:0] OP_CLEAR    = 3'd4;

  localparam logic [1:0] INSN_NOP = 2'b10;

  localparam int CNT_MAX = (SCAN_CYCLES > CLR_CYCLES) ? SCAN_CYCLES : CLR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      bitmap;
  logic             mode;
  logic             scanned;
  logic             accept;

  logic             nxt_rst_n;
  logic [1:0]       nxt_insn;
  logic             nxt_load;
  logic             nxt_run;
  logic [3:0]       nxt_index;
  logic [3:0]       nxt_data;

  // Only the index field of the datapath result is consumed here
  logic unused_dp_out;
  assign unused_dp_out = ^dp_out[11:4];

  assign bus.cmd_ready = (state == S_IDLE) & ~rst;
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_INIT_MIN, OP_INIT_MAX: next_state = S_INIT;
            OP_LOAD:                  next_state = S_LOAD;
            OP_RUN:                   next_state = scanned ? S_RESP : S_PRE;
            OP_CLEAR:                 next_state = S_CLR;
            default:                  next_state = S_IDLE;
          endcase
        end
      end
      S_INIT, S_LOAD: next_state = S_IDLE;
      S_CLR:          if (cnt == '0) next_state = S_IDLE;
      S_PRE:          next_state = S_RUN;
      S_RUN:          if (cnt == '0) next_state = S_CAPT;
      S_CAPT:         next_state = S_RESP;
      S_RESP:         if (bus.res_valid & bus.res_ready) next_state = S_IDLE;
      default:        next_state = S_IDLE;
    endcase
  end

  // Datapath strobes are decoded from next_state so the registered copy lines up with the state
  always_comb begin
    nxt_rst_n = 1'b1;
    nxt_insn  = INSN_NOP;
    nxt_load  = 1'b0;
    nxt_run   = 1'b0;
    nxt_index = dp_index;
    nxt_data  = dp_data;
    case (next_state)
      S_INIT: nxt_insn = {1'b0, bus.cmd_op[0]};
      S_LOAD: begin
        nxt_load  = 1'b1;
        nxt_insn  = {1'b0, mode};
        nxt_index = bus.cmd_index;
        nxt_data  = bus.cmd_data;
      end
      S_CLR:  nxt_rst_n = 1'b0;
      S_PRE:  nxt_insn = {1'b0, mode};
      S_RUN: begin
        nxt_run  = 1'b1;
        nxt_insn = {1'b0, mode};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_rst_n      <= 1'b0;
      dp_insn       <= INSN_NOP;
      dp_load       <= 1'b0;
      dp_run        <= 1'b0;
      dp_index      <= 4'd0;
      dp_data       <= 4'd0;
      cnt           <= '0;
      bitmap        <= 16'd0;
      mode          <= 1'b0;
      scanned       <= 1'b0;
      bad_cmd       <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_index <= 4'd0;
      bus.res_found <= 1'b0;
      bus.res_stale <= 1'b0;
    end else begin
      dp_rst_n <= nxt_rst_n;
      dp_insn  <= nxt_insn;
      dp_load  <= nxt_load;
      dp_run   <= nxt_run;
      dp_index <= nxt_index;
      dp_data  <= nxt_data;

      if (accept) begin
        case (bus.cmd_op)
          OP_INIT_MIN, OP_INIT_MAX: mode <= bus.cmd_op[0];
          OP_LOAD:                  bitmap[bus.cmd_index] <= 1'b1;
          OP_RUN:                   if (scanned) bus.res_stale <= 1'b1;
          OP_CLEAR: begin
            bitmap  <= 16'd0;
            scanned <= 1'b0;
            cnt     <= CLR_LAST;
          end
          default:                  bad_cmd <= 1'b1;
        endcase
      end

      if (state == S_PRE)
        cnt <= SCAN_LAST;
      else if ((state == S_RUN || state == S_CLR) && cnt != '0)
        cnt <= cnt - 1'b1;

      if (state == S_CAPT) begin
        bus.res_index <= (|bitmap) ? dp_out[3:0] : 4'd0;
        bus.res_found <= |bitmap;
        scanned       <= 1'b1;
      end

      bus.res_valid <= (next_state == S_RESP);
      if (state == S_RESP && bus.res_valid && bus.res_ready)
        bus.res_stale <= 1'b0;
    end
  end

`ifdef DMADD_SEQ_CHECK_EN
  // MIN expects the lowest loaded index, MAX the highest
  function automatic logic [3:0] expect_index(input logic [15:0] bm, input logic max_mode);
    logic [3:0] idx;
    idx = 4'd0;
    if (max_mode) begin
      for (int i = 0; i < 16; i++)
        if (bm[i]) idx = i[3:0];
    end else begin
      for (int i = 15; i >= 0; i--)
        if (bm[i]) idx = i[3:0];
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      res_err <= 1'b0;
    else if (state == S_CAPT)
      res_err <= (|bitmap) && (dp_out[3:0] != expect_index(bitmap, mode));
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmadd_seq.sv
// ------------------------------------------------------------------
// tb_dmadd_seq : table-driven self-checking bench for dmadd_seq
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_dmadd_seq;

  typedef struct {
    logic [2:0] op;
    logic [3:0] idx;
    logic [3:0] data;
    logic [3:0] dpo;
    int         hold;
    logic [3:0] exp_index;
    logic       exp_found;
    logic       exp_stale;
    int         exp_lat;
    int         exp_runs;
    logic       exp_bad;
  } vec_t;

  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bad_cmd;
  logic        dp_rst_n;
  logic [3:0]  dp_index;
  logic [3:0]  dp_data;
  logic [1:0]  dp_insn;
  logic        dp_load;
  logic        dp_run;
  logic [11:0] dp_out = 12'd0;
`ifdef DMADD_SEQ_CHECK_EN
  logic        res_err;
`endif

  int   total = 0;
  int   bad   = 0;
  logic tb_mode = 1'b0;
  vec_t vecs [NV];

  dmadd_seq_if bus ();

  dmadd_seq dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .bad_cmd  (bad_cmd),
    .dp_rst_n (dp_rst_n),
    .dp_index (dp_index),
    .dp_data  (dp_data),
    .dp_insn  (dp_insn),
    .dp_load  (dp_load),
    .dp_run   (dp_run),
    .dp_out   (dp_out)
`ifdef DMADD_SEQ_CHECK_EN
    ,
    .res_err  (res_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] idx, input logic [3:0] data,
                              input logic [3:0] dpo, input int hold, input logic [3:0] ei,
                              input logic ef, input logic es, input int el, input int er,
                              input logic eb);
    vec_t v;
    v.op = op; v.idx = idx; v.data = data; v.dpo = dpo; v.hold = hold;
    v.exp_index = ei; v.exp_found = ef; v.exp_stale = es;
    v.exp_lat = el; v.exp_runs = er; v.exp_bad = eb;
    return v;
  endfunction

  task automatic send(input logic [2:0] op, input logic [3:0] idx, input logic [3:0] data);
    int n;
    n = 0;
    bus.cmd_op    = op;
    bus.cmd_index = idx;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    int         lat;
    int         runs;
    int         insn_bad;
    int         hold_bad;
    logic [4:0] exp_ctl;
    dp_out = {8'h5A, v.dpo};
    send(v.op, v.idx, v.data);
    if (v.op == 3'd3) begin
      lat = 1; runs = 0; insn_bad = 0;
      while (!bus.res_valid && lat < 100) begin
        if (dp_run) begin
          runs++;
          if (dp_insn != {1'b0, tb_mode}) insn_bad++;
        end
        @(posedge clk); #1;
        lat++;
      end
      chk("run_latency", 32'(lat), 32'(v.exp_lat));
      chk("run_cycles", 32'(runs), 32'(v.exp_runs));
      chk("run_insn", 32'(insn_bad), 32'd0);
      chk("res_index", 32'(bus.res_index), 32'(v.exp_index));
      chk("res_found", 32'(bus.res_found), 32'(v.exp_found));
      chk("res_stale", 32'(bus.res_stale), 32'(v.exp_stale));
      hold_bad = 0;
      for (int h = 0; h < v.hold; h++) begin
        @(posedge clk); #1;
        if (!bus.res_valid || bus.cmd_ready || bus.res_index != v.exp_index) hold_bad++;
      end
      if (v.hold > 0) chk("res_hold", 32'(hold_bad), 32'd0);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      chk("res_release", 32'({bus.res_valid, bus.res_stale, bus.cmd_ready}), 32'b001);
    end else begin
      case (v.op)
        3'd0, 3'd1: exp_ctl = {1'b1, 1'b0, v.op[0], 2'b00};
        3'd2:       exp_ctl = {1'b1, 1'b0, tb_mode, 2'b10};
        3'd4:       exp_ctl = {1'b0, 2'b10, 2'b00};
        default:    exp_ctl = {1'b1, 2'b10, 2'b00};
      endcase
      chk("dp_ctl", 32'({dp_rst_n, dp_insn, dp_load, dp_run}), 32'(exp_ctl));
      if (v.op == 3'd2) chk("dp_load_bus", 32'({dp_index, dp_data}), 32'({v.idx, v.data}));
      if (v.op == 3'd0 || v.op == 3'd1) tb_mode = v.op[0];
      @(posedge clk); #1;
    end
    chk("bad_cmd", 32'(bad_cmd), 32'(v.exp_bad));
  endtask

  initial begin
    int   lat;
    int   runs;
    logic seen;

    //             op    idx    data   dpo    hold ei     ef    es    lat runs bad
    vecs[0]  = mk(3'd4, 4'd0,  4'd0,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[1]  = mk(3'd0, 4'd0,  4'd0,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[2]  = mk(3'd2, 4'd5,  4'd3,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[3]  = mk(3'd2, 4'd9,  4'd7,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[4]  = mk(3'd3, 4'd0,  4'd0,  4'd5,  2,   4'd5,  1'b1, 1'b0, 20, 17, 1'b0);
    vecs[5]  = mk(3'd3, 4'd0,  4'd0,  4'd0,  0,   4'd5,  1'b1, 1'b1, 1,  0,  1'b0);
    vecs[6]  = mk(3'd4, 4'd0,  4'd0,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[7]  = mk(3'd1, 4'd0,  4'd0,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[8]  = mk(3'd2, 4'd2,  4'hA,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[9]  = mk(3'd2, 4'd14, 4'hC,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[10] = mk(3'd2, 4'd14, 4'hC,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[11] = mk(3'd3, 4'd0,  4'd0,  4'd14, 10,  4'd14, 1'b1, 1'b0, 20, 17, 1'b0);
    vecs[12] = mk(3'd4, 4'd0,  4'd0,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[13] = mk(3'd3, 4'd0,  4'd0,  4'd7,  0,   4'd0,  1'b0, 1'b0, 20, 17, 1'b0);
    vecs[14] = mk(3'd3, 4'd0,  4'd0,  4'd7,  0,   4'd0,  1'b0, 1'b1, 1,  0,  1'b0);
    vecs[15] = mk(3'd4, 4'd0,  4'd0,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[16] = mk(3'd2, 4'd15, 4'd1,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[17] = mk(3'd0, 4'd0,  4'd0,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b0);
    vecs[18] = mk(3'd3, 4'd0,  4'd0,  4'd15, 0,   4'd15, 1'b1, 1'b0, 20, 17, 1'b0);
    vecs[19] = mk(3'd6, 4'd3,  4'd3,  4'd0,  0,   4'd0,  1'b0, 1'b0, 0,  0,  1'b1);

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_index = 4'd0;
    bus.cmd_data  = 4'd0;
    bus.res_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_res", 32'({bus.res_valid, bus.res_index, bus.res_found, bus.res_stale}), 32'd0);
    chk("rst_bad_cmd", 32'(bad_cmd), 32'd0);
    chk("rst_dp_ctl", 32'({dp_rst_n, dp_insn, dp_load, dp_run}), 32'b0_10_00);
    chk("rst_dp_bus", 32'({dp_index, dp_data}), 32'd0);
`ifdef DMADD_SEQ_CHECK_EN
    chk("rst_res_err", 32'(res_err), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rel_dp_insn", 32'(dp_insn), 32'b10);
    @(posedge clk); #1;
    chk("idle_dp_rst_n", 32'(dp_rst_n), 32'd1);

    for (int i = 0; i < NV; i++) apply_vec(vecs[i]);

`ifdef DMADD_SEQ_CHECK_EN
    // datapath reports 3 while the lowest loaded index is 5
    apply_vec(mk(3'd4, 4'd0, 4'd0, 4'd0, 0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1));
    apply_vec(mk(3'd0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1));
    apply_vec(mk(3'd2, 4'd5, 4'd1, 4'd0, 0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1));
    apply_vec(mk(3'd2, 4'd9, 4'd1, 4'd0, 0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1));
    apply_vec(mk(3'd3, 4'd0, 4'd0, 4'd3, 0, 4'd3, 1'b1, 1'b0, 20, 17, 1'b1));
    chk("res_err_set", 32'(res_err), 32'd1);
    apply_vec(mk(3'd3, 4'd0, 4'd0, 4'd5, 0, 4'd3, 1'b1, 1'b1, 1, 0, 1'b1));
    chk("res_err_stale_keep", 32'(res_err), 32'd1);
`endif

    // reset in the 8th dp_run cycle of a fresh scan
    apply_vec(mk(3'd4, 4'd0, 4'd0, 4'd0, 0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1));
    apply_vec(mk(3'd2, 4'd3, 4'd2, 4'd0, 0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1));
    dp_out = 12'h003;
    send(3'd3, 4'd0, 4'd0);
    lat = 1; runs = 0;
    while (runs < 8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (dp_run) runs++;
    end
    chk("abort_reach_run8", 32'(runs), 32'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_dp_run", 32'({dp_run, dp_rst_n, bus.res_valid, bus.cmd_ready, bad_cmd}), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    // scanned was cleared by reset, so this scan is fresh and the bitmap empty
    apply_vec(mk(3'd3, 4'd0, 4'd0, 4'd3, 0, 4'd0, 1'b0, 1'b0, 20, 17, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
